// File: rtl/pcs_pkg.sv
// Shared definitions for the 10GBASE-R PCS transmit path.
// Used by the TX sequencing controller, the gearbox sequence generator and the encoder.
package pcs_pkg;

    localparam int SEQ_MAX = 32;
    localparam int SEQ_W   = 6;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } tx_ctrl_state_t;

    // Idle control block: sync header 10, block type 0x1E, eight /I/ codes of 7'h00.
    localparam logic [1:0]  IDLE_SYNC_HDR   = 2'b10;
    localparam logic [7:0]  IDLE_BLOCK_TYPE = 8'h1E;
    localparam logic [65:0] IDLE_BLOCK      = {IDLE_SYNC_HDR, 56'h0, IDLE_BLOCK_TYPE};

    function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] seq, input int seq_max);
        return (seq == SEQ_W'(seq_max)) ? '0 : seq + SEQ_W'(1);
    endfunction

endpackage

// File: rtl/pcs_tx_ctrl_if.sv
// MAC-side and gearbox-side control signals of the PCS TX sequencing controller.
interface pcs_tx_ctrl_if #(
    parameter int IDLE_W = 16
);
    import pcs_pkg::*;

    logic              i_gt_tx_ready;
    logic [IDLE_W-1:0] i_idle_blocks;
    logic [SEQ_W-1:0]  o_seq_cnt;
    logic              o_gearbox_pause;
    logic              o_blk_phase;
    logic              o_idle_insert;
    logic              o_mac_ready;
    logic              o_tx_up;

    modport master (
        output i_gt_tx_ready, i_idle_blocks,
        input  o_seq_cnt, o_gearbox_pause, o_blk_phase, o_idle_insert, o_mac_ready, o_tx_up
    );

    modport slave (
        input  i_gt_tx_ready, i_idle_blocks,
        output o_seq_cnt, o_gearbox_pause, o_blk_phase, o_idle_insert, o_mac_ready, o_tx_up
    );

endinterface

// File: rtl/gearbox_seq_cnt.sv
// Gearbox sequence counter with block-half phase and pause generation.
// pause_nxt is the look-ahead of pause so callers can register pause-dependent outputs.
module gearbox_seq_cnt
    import pcs_pkg::*;
#(
    parameter int SEQ_MAX = 32,
    parameter int SEQ_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEQ_W-1:0] seq_cnt,
    output logic             phase,
    output logic             pause,
    output logic             pause_nxt
);

    logic [SEQ_W-1:0] seq_nxt;
    logic             phase_nxt;

    // Phase holds through the pause so every period starts on a block boundary.
    always_comb begin
        seq_nxt   = seq_cnt;
        phase_nxt = phase;
        if (clr) begin
            seq_nxt   = '0;
            phase_nxt = 1'b0;
        end else if (en) begin
            seq_nxt = seq_next(seq_cnt, SEQ_MAX);
            if (!pause) begin
                phase_nxt = ~phase;
            end
        end
        pause_nxt = (seq_nxt == SEQ_W'(SEQ_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_cnt <= '0;
            phase   <= 1'b0;
            pause   <= 1'b0;
        end else begin
            seq_cnt <= seq_nxt;
            phase   <= phase_nxt;
            pause   <= pause_nxt;
        end
    end

endmodule

// File: rtl/pcs_tx_ctrl.sv
// 10GBASE-R PCS TX sequencing controller: holds the path in forced idle until the GTY TX
// is ready and the requested idle blocks have gone out, then releases the MAC block-aligned.
module pcs_tx_ctrl
    import pcs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEQ_MAX    = 32,
    parameter int IDLE_W     = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    pcs_tx_ctrl_if.slave  bus
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("pcs_tx_ctrl supports DATA_WIDTH = 32 only");
    end

    localparam logic [1:0] S_RESET = RESET;
    localparam logic [1:0] S_FILL  = FILL;
    localparam logic [1:0] S_RUN   = RUN;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [IDLE_W-1:0] blk_cnt;
    logic [IDLE_W-1:0] blk_cnt_nxt;

    logic              seq_clr;
    logic [SEQ_W-1:0]  seq_cnt;
    logic              phase;
    logic              pause;
    logic              pause_nxt;
    logic              block_done;

    logic              idle_insert;
    logic              mac_ready;
    logic              tx_up;

    assign seq_clr    = ~bus.i_gt_tx_ready | (state == S_RESET);
    assign block_done = phase & ~pause;

    gearbox_seq_cnt #(
        .SEQ_MAX (SEQ_MAX),
        .SEQ_W   (SEQ_W)
    ) u_seq (
        .clk       (i_clk),
        .rst       (i_reset),
        .clr       (seq_clr),
        .en        (1'b1),
        .seq_cnt   (seq_cnt),
        .phase     (phase),
        .pause     (pause),
        .pause_nxt (pause_nxt)
    );

    // A pause right after the last fill block stays in FILL, so RUN always opens a period.
    always_comb begin
        state_nxt   = state;
        blk_cnt_nxt = blk_cnt;
        if (!bus.i_gt_tx_ready) begin
            state_nxt   = S_RESET;
            blk_cnt_nxt = '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (bus.i_idle_blocks != '0) begin
                        state_nxt   = S_FILL;
                        blk_cnt_nxt = bus.i_idle_blocks;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
                S_FILL: begin
                    if (block_done) begin
                        blk_cnt_nxt = blk_cnt - IDLE_W'(1);
                    end
                    if ((blk_cnt == '0) ||
                        (block_done && (blk_cnt == IDLE_W'(1)) && !pause_nxt)) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    state_nxt = S_RUN;
                end
                default: begin
                    state_nxt   = S_RESET;
                    blk_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_RESET;
            blk_cnt     <= '0;
            idle_insert <= 1'b1;
            mac_ready   <= 1'b0;
            tx_up       <= 1'b0;
        end else begin
            state       <= state_nxt;
            blk_cnt     <= blk_cnt_nxt;
            idle_insert <= (state_nxt != S_RUN);
            mac_ready   <= (state_nxt == S_RUN) & ~pause_nxt;
            tx_up       <= (state_nxt == S_RUN);
        end
    end

    assign bus.o_seq_cnt       = seq_cnt;
    assign bus.o_gearbox_pause = pause;
    assign bus.o_blk_phase     = phase;
    assign bus.o_idle_insert   = idle_insert;
    assign bus.o_mac_ready     = mac_ready;
    assign bus.o_tx_up         = tx_up;

endmodule

// File: tb/tb_pcs_tx_ctrl.sv
// Self-checking bench for pcs_tx_ctrl: a cycle model pushes expected outputs to a
// scoreboard as each cycle is driven, and per-feature tasks check scenario properties.
module tb_pcs_tx_ctrl;

    typedef struct {
        logic [5:0] seq;
        logic       pause;
        logic       phase;
        logic       idle_insert;
        logic       mac_ready;
        logic       tx_up;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    exp_t sb[$];
    exp_t mon_e;

    bit   m_up     = 1'b0;
    int   m_t      = 0;
    int   m_run_at = 0;

    always #5 clk = ~clk;

    pcs_tx_ctrl_if #(.IDLE_W(16)) bus ();

    pcs_tx_ctrl #(
        .DATA_WIDTH (32),
        .SEQ_MAX    (32),
        .IDLE_W     (16)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Completed blocks before cycle t of a 33-cycle period: 16 per period, one per odd seq.
    function automatic int blocks_before(input int t);
        return (t / 33) * 16 + (t % 33) / 2;
    endfunction

    function automatic int calc_run_at(input int n);
        int t = 0;
        if (n == 0) return 0;
        while (blocks_before(t) < n) t++;
        if (t % 33 == 32) t++;
        return t;
    endfunction

    // Drives one cycle, predicts the outputs after the coming edge and queues them.
    task automatic step(input logic rst_v, input logic rdy, input logic [15:0] idle);
        exp_t e;
        int   s;
        @(negedge clk);
        rst = rst_v;
        bus.i_gt_tx_ready = rdy;
        bus.i_idle_blocks = idle;
        if (rst_v || !rdy) begin
            m_up = 1'b0;
        end else if (!m_up) begin
            m_up     = 1'b1;
            m_t      = 0;
            m_run_at = calc_run_at(int'(idle));
        end else begin
            m_t++;
        end
        e.cyc = cyc_no;
        cyc_no++;
        if (!m_up) begin
            e.seq = 6'd0; e.pause = 1'b0; e.phase = 1'b0;
            e.idle_insert = 1'b1; e.mac_ready = 1'b0; e.tx_up = 1'b0;
        end else begin
            s = m_t % 33;
            e.seq         = 6'(s);
            e.pause       = (s == 32);
            e.phase       = (s % 2 == 1);
            e.tx_up       = (m_t >= m_run_at);
            e.idle_insert = !e.tx_up;
            e.mac_ready   = e.tx_up && !e.pause;
        end
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (bus.o_seq_cnt !== mon_e.seq) begin
                n_fail++;
                $display("[TB] FAIL seq_cnt cycle %0d: got %0d expected %0d", mon_e.cyc, bus.o_seq_cnt, mon_e.seq);
            end
            n_checks++;
            if (bus.o_gearbox_pause !== mon_e.pause) begin
                n_fail++;
                $display("[TB] FAIL gearbox_pause cycle %0d: got %b expected %b", mon_e.cyc, bus.o_gearbox_pause, mon_e.pause);
            end
            n_checks++;
            if (bus.o_blk_phase !== mon_e.phase) begin
                n_fail++;
                $display("[TB] FAIL blk_phase cycle %0d: got %b expected %b", mon_e.cyc, bus.o_blk_phase, mon_e.phase);
            end
            n_checks++;
            if (bus.o_idle_insert !== mon_e.idle_insert) begin
                n_fail++;
                $display("[TB] FAIL idle_insert cycle %0d: got %b expected %b", mon_e.cyc, bus.o_idle_insert, mon_e.idle_insert);
            end
            n_checks++;
            if (bus.o_mac_ready !== mon_e.mac_ready) begin
                n_fail++;
                $display("[TB] FAIL mac_ready cycle %0d: got %b expected %b", mon_e.cyc, bus.o_mac_ready, mon_e.mac_ready);
            end
            n_checks++;
            if (bus.o_tx_up !== mon_e.tx_up) begin
                n_fail++;
                $display("[TB] FAIL tx_up cycle %0d: got %b expected %b", mon_e.cyc, bus.o_tx_up, mon_e.tx_up);
            end
        end
    end

    task automatic test_reset();
        bus.i_gt_tx_ready = 1'b0;
        bus.i_idle_blocks = 16'd0;
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_seq_cnt !== 6'd0) begin n_fail++; $display("[TB] FAIL reset seq_cnt: got %0d expected 0", bus.o_seq_cnt); end
        n_checks++;
        if (bus.o_gearbox_pause !== 1'b0) begin n_fail++; $display("[TB] FAIL reset gearbox_pause: got %b expected 0", bus.o_gearbox_pause); end
        n_checks++;
        if (bus.o_blk_phase !== 1'b0) begin n_fail++; $display("[TB] FAIL reset blk_phase: got %b expected 0", bus.o_blk_phase); end
        n_checks++;
        if (bus.o_idle_insert !== 1'b1) begin n_fail++; $display("[TB] FAIL reset idle_insert: got %b expected 1", bus.o_idle_insert); end
        n_checks++;
        if (bus.o_mac_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset mac_ready: got %b expected 0", bus.o_mac_ready); end
        n_checks++;
        if (bus.o_tx_up !== 1'b0) begin n_fail++; $display("[TB] FAIL reset tx_up: got %b expected 0", bus.o_tx_up); end
        step(1'b1, 1'b0, 16'd0);
        step(1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_fill4();
        int         first_rdy = -1;
        int         fill_cycles = 0;
        logic [5:0] seq_at = 6'h3F;
        logic       phase_at = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, (i == 3) ? 16'd9 : 16'd4);
            if (bus.o_idle_insert === 1'b1) fill_cycles++;
            if (first_rdy < 0 && bus.o_mac_ready === 1'b1) begin
                first_rdy = i;
                seq_at    = bus.o_seq_cnt;
                phase_at  = bus.o_blk_phase;
            end
        end
        n_checks++;
        if (first_rdy != 8) begin n_fail++; $display("[TB] FAIL fill4 first mac_ready index: got %0d expected 8", first_rdy); end
        n_checks++;
        if (seq_at !== 6'd8) begin n_fail++; $display("[TB] FAIL fill4 seq at release: got %0d expected 8", seq_at); end
        n_checks++;
        if (phase_at !== 1'b0) begin n_fail++; $display("[TB] FAIL fill4 phase at release: got %b expected 0", phase_at); end
        n_checks++;
        if (fill_cycles != 8) begin n_fail++; $display("[TB] FAIL fill4 fill cycles: got %0d expected 8", fill_cycles); end
        step(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_fill16();
        int         first_up = -1;
        int         fill_cycles = 0;
        int         pause_in_fill = 0;
        logic [5:0] seq_at = 6'h3F;
        logic       phase_at = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 16'd16);
            if (bus.o_idle_insert === 1'b1) fill_cycles++;
            if (bus.o_idle_insert === 1'b1 && bus.o_gearbox_pause === 1'b1) pause_in_fill++;
            if (first_up < 0 && bus.o_tx_up === 1'b1) begin
                first_up = i;
                seq_at   = bus.o_seq_cnt;
                phase_at = bus.o_blk_phase;
            end
        end
        n_checks++;
        if (fill_cycles != 33) begin n_fail++; $display("[TB] FAIL fill16 fill cycles: got %0d expected 33", fill_cycles); end
        n_checks++;
        if (pause_in_fill != 1) begin n_fail++; $display("[TB] FAIL fill16 pauses inside fill: got %0d expected 1", pause_in_fill); end
        n_checks++;
        if (first_up != 33) begin n_fail++; $display("[TB] FAIL fill16 run entry index: got %0d expected 33", first_up); end
        n_checks++;
        if (seq_at !== 6'd0 || phase_at !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fill16 run entry alignment: got seq %0d phase %b expected seq 0 phase 0", seq_at, phase_at);
        end
        step(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_run_200();
        int   ready_cnt = 0;
        int   pause_cnt = 0;
        int   bad_pos = 0;
        int   toggles = 0;
        logic prev_pause = 1'b0;
        logic prev_phase = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, 16'd0);
            if (i == 0) begin
                n_checks++;
                if (bus.o_idle_insert !== 1'b0 || bus.o_mac_ready !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL zero-fill immediate run: got idle_insert %b mac_ready %b expected 0 1", bus.o_idle_insert, bus.o_mac_ready);
                end
            end
            if (bus.o_mac_ready === 1'b1) ready_cnt++;
            if (bus.o_gearbox_pause === 1'b1) begin
                pause_cnt++;
                if (i != 32 + 33 * (pause_cnt - 1)) bad_pos++;
            end
            if (prev_pause && bus.o_blk_phase !== prev_phase) toggles++;
            prev_pause = bus.o_gearbox_pause;
            prev_phase = bus.o_blk_phase;
        end
        n_checks++;
        if (ready_cnt != 194) begin n_fail++; $display("[TB] FAIL run200 mac_ready count: got %0d expected 194", ready_cnt); end
        n_checks++;
        if (pause_cnt != 6) begin n_fail++; $display("[TB] FAIL run200 pause count: got %0d expected 6", pause_cnt); end
        n_checks++;
        if (bad_pos != 0) begin n_fail++; $display("[TB] FAIL run200 misplaced pauses: got %0d expected 0", bad_pos); end
        n_checks++;
        if (toggles != 0) begin n_fail++; $display("[TB] FAIL run200 phase toggles across pause: got %0d expected 0", toggles); end
        step(1'b0, 1'b0, 16'd0);
    endtask

    task automatic test_ready_drop();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b1, 16'd0);
            if (bus.o_seq_cnt === 6'd17) found = 1'b1;
        end
        n_checks++;
        if (!found || bus.o_blk_phase !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drop reach seq 17 phase 1: got found %0d phase %b expected 1 1", found, bus.o_blk_phase);
        end
        step(1'b0, 1'b0, 16'd5);
        n_checks++;
        if (bus.o_seq_cnt !== 6'd0 || bus.o_blk_phase !== 1'b0 || bus.o_tx_up !== 1'b0 || bus.o_idle_insert !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drop outputs: got seq %0d phase %b tx_up %b idle %b expected 0 0 0 1",
                     bus.o_seq_cnt, bus.o_blk_phase, bus.o_tx_up, bus.o_idle_insert);
        end
        step(1'b0, 1'b1, 16'd0);
        n_checks++;
        if (bus.o_seq_cnt !== 6'd0 || bus.o_tx_up !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drop restart: got seq %0d tx_up %b expected 0 1", bus.o_seq_cnt, bus.o_tx_up);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 16'd2);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_seq_cnt !== 6'd0 || bus.o_gearbox_pause !== 1'b0 || bus.o_blk_phase !== 1'b0 ||
            bus.o_idle_insert !== 1'b1 || bus.o_mac_ready !== 1'b0 || bus.o_tx_up !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async reset outputs: got seq %0d pause %b phase %b idle %b mac %b up %b expected 0 0 0 1 0 0",
                     bus.o_seq_cnt, bus.o_gearbox_pause, bus.o_blk_phase, bus.o_idle_insert, bus.o_mac_ready, bus.o_tx_up);
        end
        step(1'b1, 1'b1, 16'd3);
        step(1'b1, 1'b1, 16'd3);
        step(1'b0, 1'b1, 16'd3);
        n_checks++;
        if (bus.o_idle_insert !== 1'b1 || bus.o_seq_cnt !== 6'd0 || bus.o_tx_up !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async reset re-entry: got idle %b seq %0d up %b expected 1 0 0",
                     bus.o_idle_insert, bus.o_seq_cnt, bus.o_tx_up);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 16'd3);
        end
    endtask

    initial begin
        test_reset();
        test_fill4();
        test_fill16();
        test_run_200();
        test_ready_drop();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcs_tx_ctrl.md
# pcs_tx_ctrl

TX sequencing controller for the 10GBASE-R PCS transmit path. It sits between the XGMII MAC interface and the 64b/66b encoder → scrambler → synchronous gearbox chain. It owns the 33-cycle gearbox sequence, generates the gearbox pause and block-half phase, and holds the path in forced-idle until the GTY TX is ready and a configurable number of idle blocks has gone out. It then releases the MAC.

## Interface
- DATA_WIDTH, 32: datapath word width; only 32 is supported.
- SEQ_MAX, 32: last gearbox sequence value; the counter period is SEQ_MAX+1.
- IDLE_W, 16: width of the idle-fill block count.

Ports:
- i_clk  in  1  GTY TX user clock (txusrclk2); the only clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_gt_tx_ready  in  1  GTY TX reset-done, already synchronous to i_clk.
- i_idle_blocks  in  IDLE_W  idle blocks sent after TX ready, before MAC release; sampled on the RESET→FILL transition.
- o_seq_cnt  out  6  gearbox sequence count, 0..SEQ_MAX.
- o_gearbox_pause  out  1  gearbox absorbs header bits this cycle; no word is consumed.
- o_blk_phase  out  1  0 = first 32-bit half of a 64-bit block, 1 = second half.
- o_idle_insert  out  1  encoder must emit idle control blocks and ignore XGMII.
- o_mac_ready  out  1  MAC may present a valid XGMII word this cycle.
- o_tx_up  out  1  controller is in RUN.

## Operation
- FSM states: RESET, FILL, RUN.
- RESET:
  - seq = 0, phase = 0, block counter = 0.
  - Exits when i_gt_tx_ready = 1.
  - Goes to FILL if i_idle_blocks ≠ 0 (block counter loaded with i_idle_blocks); goes to RUN if i_idle_blocks = 0.
- FILL:
  - Block counter decrements on each completed block (phase = 1 on a non-pause cycle).
  - When the counter reaches 0, the next state is RUN.
- RUN: steady state; stays in RUN until i_gt_tx_ready drops.
- i_gt_tx_ready = 0 in any state: next state is RESET. seq, phase and counter are cleared at that same edge, even mid-block.
- Sequence counter (FILL, RUN):
  - Increments every cycle and wraps SEQ_MAX → 0.
  - Each period is 32 data words (16 blocks) plus 1 pause = 1056 bits = 33 × 32.
- Pause: o_gearbox_pause = 1 exactly when seq = SEQ_MAX.
- Phase:
  - Toggles on every non-pause cycle and holds across the pause cycle.
  - Phase is 0 when seq = 0, so a block never straddles a period boundary.
- Outputs:
  - o_idle_insert = 1 in RESET and FILL.
  - o_mac_ready = RUN & ~pause.
  - o_tx_up = RUN.
- RUN entry always lands on phase 0, so MAC data is always block-aligned.
- A change of i_idle_blocks outside the RESET→FILL edge has no effect.

## Timing
- All outputs are registered.
- Reset values: o_seq_cnt = 0, o_gearbox_pause = 0, o_blk_phase = 0, o_idle_insert = 1, o_mac_ready = 0, o_tx_up = 0.
- First cycle after i_gt_tx_ready rises: state = FILL/RUN, o_seq_cnt = 0, o_blk_phase = 0.
- Pause is high for 1 cycle in every 33, in the cycle o_seq_cnt = 32. o_mac_ready is low in that same cycle.
- FILL duration = 2·N + pause cycles falling inside it. o_mac_ready rises on the cycle after the phase-1 word of the Nth block.
- If i_gt_tx_ready falls at edge k, all outputs are at reset values from cycle k+1 onward.
- Asynchronous i_reset forces reset values immediately, independent of the clock.

## Structure
- Shared package pcs_pkg holds:
  - the tx_ctrl_state_t enum {RESET, FILL, RUN};
  - the SEQ_MAX and SEQ_W constants;
  - the encoder idle-block constant (so the encoder and this block agree).
- One natural sub-module, gearbox_seq_cnt: the seq/phase/pause generator with an enable and a synchronous clear. The gearbox testbench reuses it as a reference model.
- The FSM and fill counter stay in pcs_tx_ctrl.

## Test plan
- Reset, then i_gt_tx_ready = 1 with i_idle_blocks = 4 → FILL for 8 cycles. o_mac_ready first rises at cycle 9 with o_seq_cnt = 8 and o_blk_phase = 0.
- i_idle_blocks = 16 → pause at seq 32 falls inside FILL. FILL lasts 33 cycles; RUN is entered with seq = 0 and phase = 0.
- RUN for 200 cycles → pause high exactly at cycles 32, 65, 98, 131, 164, 197. Phase never toggles on those cycles. o_mac_ready count = 194.
- i_idle_blocks = 0 → RUN on the first ready cycle with o_idle_insert = 0. o_mac_ready is high immediately.
- i_gt_tx_ready dropped at seq 17, phase 1 → next cycle RESET, all outputs at reset values. Ready re-asserted → seq restarts at 0.
- Asynchronous i_reset asserted mid-RUN between clock edges → outputs at reset values before the next edge. State is RESET after release.
